// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a 3-stage pixel pipeline (request, sample, drive),
// built-in test patterns and a debounced pushbutton that steps the pattern mode per frame.
module vga_timing_gen #(
  parameter int H_SYNC    = 44,
  parameter int H_BP      = 148,
  parameter int H_ACT     = 1920,
  parameter int H_FP      = 88,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 36,
  parameter int V_ACT     = 1080,
  parameter int V_FP      = 4,
  parameter int HS_POL    = 1,
  parameter int VS_POL    = 1,
  parameter int DB_CYCLES = 1000000
) (
  input  logic        vga_clk,
  input  logic        s_rst,
  input  logic [23:0] pi_rgb_data,
  input  logic        key,
  output logic        h_sync,
  output logic        v_sync,
  output logic        de,
  output logic        po_req,
  output logic [11:0] po_x,
  output logic [11:0] po_y,
  output logic        po_start_flag,
  output logic [1:0]  po_mode,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam int H_ALL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_ALL = V_SYNC + V_BP + V_ACT + V_FP;

  generate
    if (H_ALL > 4096 || V_ALL > 4096) begin : g_bad_geometry
      $error("vga_timing_gen: H_ALL and V_ALL must not exceed 4096");
    end
  endgenerate

  // Bounds kept at 13 bits so a 4096-wide raster still compares correctly.
  localparam logic [12:0] H_LAST_L = 13'(H_ALL - 1);
  localparam logic [12:0] V_LAST_L = 13'(V_ALL - 1);
  localparam logic [12:0] H_A0_L   = 13'(H_SYNC + H_BP);
  localparam logic [12:0] H_A1_L   = 13'(H_SYNC + H_BP + H_ACT);
  localparam logic [12:0] V_A0_L   = 13'(V_SYNC + V_BP);
  localparam logic [12:0] V_A1_L   = 13'(V_SYNC + V_BP + V_ACT);
  localparam logic [12:0] H_SY_L   = 13'(H_SYNC);
  localparam logic [12:0] V_SY_L   = 13'(V_SYNC);
  localparam logic        HS_ON    = (HS_POL != 0);
  localparam logic        VS_ON    = (VS_POL != 0);
  localparam logic [11:0] BAR_W_L  = 12'((H_ACT >= 8) ? (H_ACT / 8) : 1);
  localparam int          DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [11:0]     r_h_cnt, r_v_cnt;
  logic            r_hs1, r_vs1, r_sf1;
  logic            r_req2, r_hs2, r_vs2, r_sf2, r_y2_b5;
  logic [11:0]     r_x2;
  logic            r_key_s1, r_key_s2, r_key_lvl;
  logic [DB_W-1:0] r_db_cnt;
  logic [1:0]      r_pend;

  logic [12:0] w_h, w_v;
  logic        w_active, w_first, w_wrap, w_db_rise;
  logic [11:0] w_bar;
  logic [23:0] w_bar_rgb, w_pix;

  assign w_h       = {1'b0, r_h_cnt};
  assign w_v       = {1'b0, r_v_cnt};
  assign w_active  = (w_h >= H_A0_L) && (w_h < H_A1_L) && (w_v >= V_A0_L) && (w_v < V_A1_L);
  assign w_first   = (w_h == H_A0_L) && (w_v == V_A0_L);
  assign w_wrap    = (w_h == H_LAST_L) && (w_v == V_LAST_L);
  assign w_db_rise = r_key_s2 && !r_key_lvl && (r_db_cnt == DB_LAST);

  // Free-running raster counters.
  always_ff @(posedge vga_clk) begin
    if (s_rst) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= 12'd0;
    end else if (w_h == H_LAST_L) begin
      r_h_cnt <= 12'd0;
      r_v_cnt <= (w_v == V_LAST_L) ? 12'd0 : r_v_cnt + 12'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
    end
  end

  // Stage 1: pixel request to upstream plus raw sync/start decode.
  always_ff @(posedge vga_clk) begin
    if (s_rst) begin
      po_req <= 1'b0;
      po_x   <= 12'd0;
      po_y   <= 12'd0;
      r_hs1  <= ~HS_ON;
      r_vs1  <= ~VS_ON;
      r_sf1  <= 1'b0;
    end else begin
      po_req <= w_active;
      po_x   <= w_active ? r_h_cnt - H_A0_L[11:0] : 12'd0;
      po_y   <= w_active ? r_v_cnt - V_A0_L[11:0] : 12'd0;
      r_hs1  <= (w_h < H_SY_L) ? HS_ON : ~HS_ON;
      r_vs1  <= (w_v < V_SY_L) ? VS_ON : ~VS_ON;
      r_sf1  <= w_first;
    end
  end

  // Stage 2: wait one cycle for upstream to present the requested pixel.
  always_ff @(posedge vga_clk) begin
    if (s_rst) begin
      r_req2  <= 1'b0;
      r_x2    <= 12'd0;
      r_y2_b5 <= 1'b0;
      r_hs2   <= ~HS_ON;
      r_vs2   <= ~VS_ON;
      r_sf2   <= 1'b0;
    end else begin
      r_req2  <= po_req;
      r_x2    <= po_x;
      r_y2_b5 <= po_y[5];
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      r_sf2   <= r_sf1;
    end
  end

  // Pattern source selection; bar index clamps so remainder columns use the last bar.
  always_comb begin
    w_bar     = r_x2 / BAR_W_L;
    w_bar_rgb = 24'h000000;
    w_pix     = pi_rgb_data;
    if (w_bar >= 12'd7) begin
      w_bar_rgb = 24'h000000;
    end else begin
      case (w_bar[2:0])
        3'd0:    w_bar_rgb = 24'hFFFFFF;
        3'd1:    w_bar_rgb = 24'hFFFF00;
        3'd2:    w_bar_rgb = 24'h00FFFF;
        3'd3:    w_bar_rgb = 24'h00FF00;
        3'd4:    w_bar_rgb = 24'hFF00FF;
        3'd5:    w_bar_rgb = 24'hFF0000;
        3'd6:    w_bar_rgb = 24'h0000FF;
        default: w_bar_rgb = 24'h000000;
      endcase
    end
    case (po_mode)
      2'd0:    w_pix = pi_rgb_data;
      2'd1:    w_pix = w_bar_rgb;
      2'd2:    w_pix = (r_x2[5] ^ r_y2_b5) ? 24'hFFFFFF : 24'h000000;
      2'd3:    w_pix = {r_x2[7:0], r_x2[7:0], r_x2[7:0]};
      default: w_pix = pi_rgb_data;
    endcase
  end

  // Stage 3: registered video outputs, blanked outside the active region.
  always_ff @(posedge vga_clk) begin
    if (s_rst) begin
      de            <= 1'b0;
      h_sync        <= ~HS_ON;
      v_sync        <= ~VS_ON;
      po_start_flag <= 1'b0;
      {r, g, b}     <= 24'h000000;
    end else begin
      de            <= r_req2;
      h_sync        <= r_hs2;
      v_sync        <= r_vs2;
      po_start_flag <= r_sf2;
      {r, g, b}     <= r_req2 ? w_pix : 24'h000000;
    end
  end

  // Key synchroniser, debouncer and frame-aligned mode update.
  always_ff @(posedge vga_clk) begin
    if (s_rst) begin
      r_key_s1  <= 1'b0;
      r_key_s2  <= 1'b0;
      r_key_lvl <= 1'b0;
      r_db_cnt  <= '0;
      r_pend    <= 2'd0;
      po_mode   <= 2'd0;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      if (r_key_s2 == r_key_lvl) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_key_lvl <= r_key_s2;
        r_db_cnt  <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      r_pend  <= r_pend + {1'b0, w_db_rise};
      po_mode <= w_wrap ? r_pend : po_mode;
    end
  end

endmodule
